dmem_access_unit: RTL

Data-memory access unit for the rv32i pipeline's memory stage. It takes the load and store controls from the stage's `rv32i_control_word` plus the address and store data, and runs the data-memory request/response handshake as the initiator. It generates byte enables, lane-aligned write data and sign- or zero-extended load data. It stalls the pipeline until the memory responds and flags misaligned or illegal accesses as traps without touching memory.

---
 rtl/dmem_access_unit.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
//
// Memory-stage data access unit for the rv32i pipeline. It decodes the load
// and store controls of the memory-stage instruction and checks alignment and
// width legality. A legal access runs one request/response handshake with data
// memory. The unit drives byte enables and lane-shifted store data, and returns
// sign- or zero-extended load data. Illegal or misaligned accesses raise trap
// and never reach memory.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   valid               memory-stage instruction is valid
//   data_read           instruction is a load
//   data_write          instruction is a store
//   funct3              load/store width encoding
//   addr                byte address from the ALU
//   store_data          rs2 value for stores
//   dmem_read           registered memory read request
//   dmem_write          registered memory write request
//   dmem_address        word-aligned request address
//   dmem_wdata          store data shifted into its byte lanes
//   dmem_byte_enable    byte lanes touched by the access
//   dmem_rdata          memory read data, valid with dmem_resp
//   dmem_resp           single-cycle memory response
//   stall               hold the pipeline up to and including this stage
//   load_data           extended load result, valid while done=1
//   done                one-cycle completion pulse
//   trap                misaligned or illegal access (combinational, IDLE only)
//   rmask, wmask        RVFI read/write byte masks for the access
// -----------------------------------------------------------------------------
module dmem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        trap,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask
);

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // Load widths
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store widths
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state;

  // Byte lanes covered by an access. funct3[1:0] carries the size for both
  // loads and stores (00 byte, 01 half, 10 word); the unsigned load variants
  // differ only in bit 2.
  function automatic logic [MASK_W-1:0] lane_mask(input logic [1:0] size,
                                                   input logic [1:0] off);
    logic [MASK_W-1:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Shift store data into the lanes selected by the byte offset.
  function automatic logic [DATA_W-1:0] align_store(input logic [DATA_W-1:0] data,
                                                    input logic [1:0]        off);
    return data << {off, 3'b000};
  endfunction

  // Pull the addressed bytes out of the returned word and extend them.
  function automatic logic [DATA_W-1:0] extend_load(input logic [2:0]        f3,
                                                    input logic [1:0]        off,
                                                    input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0]        shifted;
    logic signed [7:0]        byte_s;
    logic signed [15:0]       half_s;
    logic signed [DATA_W-1:0] wide_s;
    logic [DATA_W-1:0]        result;
    shifted = rdata >> {off, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    wide_s  = '0;
    result  = '0;
    case (f3)
      F3_LB: begin
        wide_s = byte_s;
        result = wide_s;
      end
      F3_LH: begin
        wide_s = half_s;
        result = wide_s;
      end
      F3_LBU:  result = {24'b0, shifted[7:0]};
      F3_LHU:  result = {16'b0, shifted[15:0]};
      F3_LW:   result = shifted;
      default: result = '0;
    endcase
    return result;
  endfunction

  // Legality of a load: reserved widths and natural alignment.
  function automatic logic load_is_bad(input logic [2:0] f3,
                                       input logic [1:0] off);
    logic b;
    case (f3)
      F3_LB, F3_LBU:  b = 1'b0;
      F3_LH, F3_LHU:  b = off[0];
      F3_LW:          b = (off != 2'b00);
      default:        b = 1'b1;
    endcase
    return b;
  endfunction

  // Legality of a store: only sb/sh/sw exist, each naturally aligned.
  function automatic logic store_is_bad(input logic [2:0] f3,
                                        input logic [1:0] off);
    logic b;
    case (f3)
      F3_SB:   b = 1'b0;
      F3_SH:   b = off[0];
      F3_SW:   b = (off != 2'b00);
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  // ---- p0: decode of the incoming memory-stage instruction ----
  logic              bad_p0;
  logic              accept_p0;
  logic [MASK_W-1:0] be_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              idle_p0;

  always_comb begin
    idle_p0  = (state == IDLE);
    bad_p0   = 1'b0;
    if (data_read && load_is_bad(funct3, addr[1:0]))
      bad_p0 = 1'b1;
    if (data_write && store_is_bad(funct3, addr[1:0]))
      bad_p0 = 1'b1;
    if (valid && data_read && data_write)
      bad_p0 = 1'b1;
    accept_p0 = idle_p0 && valid && (data_read ^ data_write) && !bad_p0;
    be_p0     = lane_mask(funct3[1:0], addr[1:0]);
    wdata_p0  = align_store(store_data, addr[1:0]);
  end

  assign trap  = idle_p0 && valid && (data_read || data_write) && bad_p0;
  assign stall = accept_p0 || (state == BUSY);

  // ---- p1: access held while the memory handshake is outstanding ----
  logic       is_load_p1;
  logic [1:0] off_p1;
  logic [2:0] funct3_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      load_data        <= '0;
      done             <= 1'b0;
      rmask            <= '0;
      wmask            <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_p0) begin
            state            <= BUSY;
            is_load_p1       <= data_read;
            off_p1           <= addr[1:0];
            funct3_p1        <= funct3;
            dmem_read        <= data_read;
            dmem_write       <= data_write;
            dmem_address     <= {addr[31:2], 2'b00};
            dmem_byte_enable <= be_p0;
            dmem_wdata       <= wdata_p0;
            rmask            <= data_read  ? be_p0 : '0;
            wmask            <= data_write ? be_p0 : '0;
          end
        end
        BUSY: begin
          // ---- p2: response captured, result presented for one cycle ----
          if (dmem_resp) begin
            state      <= DONE;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            done       <= 1'b1;
            load_data  <= is_load_p1 ? extend_load(funct3_p1, off_p1, dmem_rdata) : '0;
          end
        end
        DONE: begin
          // The pipeline advances out of this cycle, so returning to IDLE
          // cannot re-accept the same instruction.
          state <= IDLE;
          rmask <= '0;
          wmask <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
